// File: rtl/im_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package im_loader_pkg;

   localparam int NMEM_DEF = 128;
   localparam int AW_DEF   = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_DONE
   } ld_state_e;

   // Word index wraps inside the memory: (b + c) kept to the low aw bits.
   function automatic logic [31:0] wrap_idx(
      input logic [31:0] b,
      input logic [31:0] c,
      input int unsigned aw
   );
      return (b + c) & ((32'd1 << aw) - 32'd1);
   endfunction

endpackage

// File: rtl/im_wr_stage.sv
// Registered instruction-memory write port: one strobe cycle per loaded word.
module im_wr_stage #(
   parameter int AW = 7
) (
   input  logic          clk_i,
   input  logic          flush_i,
   input  logic          load_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   data_i,
   output logic [31:0]   im_add_o,
   output logic [31:0]   im_data_o,
   output logic          im_rd_wr_o
);

   logic [AW-1:0] add_q;
   logic [31:0]   data_q;
   logic          stb_q;

   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         add_q  <= '0;
         data_q <= '0;
         stb_q  <= 1'b0;
      end else begin
         stb_q <= load_i;
         if (load_i) begin
            add_q  <= addr_i;
            data_q <= data_i;
         end
      end
   end

   assign im_add_o   = {{(32-AW){1'b0}}, add_q};
   assign im_data_o  = data_q;
   assign im_rd_wr_o = stb_q;

endmodule

// File: rtl/im_loader.sv
// Program-load controller: streams host words into instruction memory, holds the core meanwhile.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int NMEM          = NMEM_DEF,
   parameter int AW            = AW_DEF,
   parameter bit HOLD_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic [AW-1:0] base,
   input  logic          abort,
   input  logic          wr_valid,
   input  logic [31:0]   wr_data,
   output logic          wr_ready,
   output logic [31:0]   im_add,
   output logic [31:0]   im_data,
   output logic          im_en,
   output logic          im_rd_wr,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [AW:0] LEN_MAX = (AW+1)'(NMEM);

   ld_state_e     state_q;
   logic [AW:0]   count_q, count_d, len_q;
   logic [AW-1:0] base_q, addr_d;
   logic          busy_q, done_q, err_q, hold_q;
   logic          hs, len_ok;

   assign wr_ready = (state_q == S_LOAD) && !abort;
   assign hs       = wr_valid && wr_ready;
   assign len_ok   = (len != '0) && (len <= LEN_MAX);
   assign count_d  = count_q + (AW+1)'(1);
   assign addr_d   = AW'(wrap_idx(32'(base_q), 32'(count_q), AW));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         len_q   <= '0;
         base_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= HOLD_ON_RESET;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: if (start) begin
               len_q   <= len;
               base_q  <= base;
               count_q <= '0;
               err_q   <= !len_ok;
               if (len_ok) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
                  hold_q  <= 1'b1;
               end
            end
            S_LOAD: if (abort) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               err_q   <= 1'b1;
            end else if (hs) begin
               count_q <= count_d;
               if (count_d == len_q) state_q <= S_SETTLE;
            end
            // Abort still leaves the core held: a partial image must never run.
            S_SETTLE: if (abort) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               err_q   <= 1'b1;
            end else begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
               hold_q  <= 1'b0;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   im_wr_stage #(.AW(AW)) u_wr (
      .clk_i      (clk),
      .flush_i    (rst),
      .load_i     (hs),
      .addr_i     (addr_d),
      .data_i     (wr_data),
      .im_add_o   (im_add),
      .im_data_o  (im_data),
      .im_rd_wr_o (im_rd_wr)
   );

   assign im_en    = busy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign cpu_hold = hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes queued at handshake, popped on strobe.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst, start, abort, wr_valid;
   logic [7:0]  len;
   logic [6:0]  base;
   logic [31:0] wr_data;
   logic        wr_ready, im_en, im_rd_wr, cpu_hold, busy, done, err;
   logic [31:0] im_add, im_data;

   typedef struct packed {
      logic [31:0] add;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  passed = 0;
   int  total  = 0;
   bit  stb_exp = 1'b0;

   always #5 clk = ~clk;

   im_loader #(.NMEM(128), .AW(7), .HOLD_ON_RESET(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .base     (base),
      .abort    (abort),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .im_add   (im_add),
      .im_data  (im_data),
      .im_en    (im_en),
      .im_rd_wr (im_rd_wr),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         passed++;
   endtask

   task automatic tick();
      wr_t e;
      @(negedge clk);
      chk("stb", 32'(im_rd_wr), 32'(stb_exp));
      if (im_rd_wr) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("im_add", im_add, e.add);
            chk("im_data", im_data, e.data);
         end else begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end
      end
      stb_exp = 1'b0;
   endtask

   task automatic push_word(input int bs, input int i, input logic [31:0] d);
      wr_t e;
      wr_valid = 1'b1;
      wr_data  = d;
      e.add    = 32'((bs + i) % 128);
      e.data   = d;
      sb.push_back(e);
      stb_exp  = 1'b1;
   endtask

   task automatic run_load(input int ln, input int bs,
                           input logic [31:0] seed, input bit gappy);
      start = 1'b1;
      len   = 8'(ln);
      base  = 7'(bs);
      tick();
      start = 1'b0;
      chk("busy_load", 32'(busy), 32'd1);
      chk("hold_load", 32'(cpu_hold), 32'd1);
      chk("im_en_load", 32'(im_en), 32'd1);
      chk("err_clear", 32'(err), 32'd0);
      for (int i = 0; i < ln; i++) begin
         push_word(bs, i, seed + 32'(i));
         #1 chk("wr_ready", 32'(wr_ready), 32'd1);
         tick();
         if (gappy && i < ln - 1) begin
            wr_valid = 1'b0;
            tick();
         end
      end
      wr_valid = 1'b0;
      chk("settle_ready", 32'(wr_ready), 32'd0);
      chk("settle_done", 32'(done), 32'd0);
      chk("settle_hold", 32'(cpu_hold), 32'd1);
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_hold", 32'(cpu_hold), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_im_en", 32'(im_en), 32'd0);
   endtask

   task automatic bad_start(input int ln, input bit hold_exp);
      start = 1'b1;
      len   = 8'(ln);
      base  = 7'd3;
      tick();
      start = 1'b0;
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_hold", 32'(cpu_hold), 32'(hold_exp));
      tick();
      chk("bad_im_en", 32'(im_en), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0;
      len = '0; base = '0; wr_data = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_add", im_add, 32'd0);
      chk("rst_data", im_data, 32'd0);
      chk("rst_im_en", 32'(im_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_ready", 32'(wr_ready), 32'd0);

      run_load(4, 0, 32'hA0, 1'b0);
      run_load(4, 126, 32'h1234_0000, 1'b0);
      run_load(2, 9, 32'hBEEF_0000, 1'b1);

      bad_start(0, 1'b0);
      bad_start(129, 1'b0);
      run_load(1, 5, 32'hC0DE_0001, 1'b0);

      // abort on the third handshake, with a stray start mid-load
      start = 1'b1; len = 8'd5; base = 7'd40;
      tick();
      start = 1'b1; len = 8'd1; base = 7'd0;
      push_word(40, 0, 32'hD000_0000);
      tick();
      start = 1'b0;
      push_word(40, 1, 32'hD000_0001);
      tick();
      abort = 1'b1;
      wr_valid = 1'b1;
      wr_data = 32'hD000_0002;
      #1 chk("abort_ready", 32'(wr_ready), 32'd0);
      tick();
      abort = 1'b0;
      wr_valid = 1'b0;
      chk("abort_err", 32'(err), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hold", 32'(cpu_hold), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      chk("abort_done2", 32'(done), 32'd0);
      tick();
      chk("abort_done3", 32'(done), 32'd0);

      // reset in LOAD drops the pending strobe
      run_load(1, 77, 32'hE000_0000, 1'b0);
      start = 1'b1; len = 8'd4; base = 7'd20;
      tick();
      start = 1'b0;
      push_word(20, 0, 32'hF000_0000);
      tick();
      rst = 1'b1;
      wr_valid = 1'b1;
      wr_data = 32'hF000_0001;
      tick();
      rst = 1'b0;
      wr_valid = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_hold", 32'(cpu_hold), 32'd1);
      chk("mrst_add", im_add, 32'd0);
      chk("mrst_err", 32'(err), 32'd0);
      tick();
      chk("mrst_ready", 32'(wr_ready), 32'd0);

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/im_loader.md
# im_loader

Program-load controller for the instruction memory. It accepts a burst of 32-bit instruction words from a host over a valid/ready stream and sequences them into the instruction memory's write port (`im_add`, `im_data`, `im_en`, `im_rd_wr`) at consecutive word indices. While a load is in progress it holds the CPU pipeline so that fetch never observes a partially written program. It sits between the host/debug link and the instruction memory, and drives the core's hold input.

## Interface
- `NMEM`, 128, number of instruction-memory words; a power of two.
- `AW`, 7, word-index width; equals log2(NMEM).
- `HOLD_ON_RESET`, 1, `cpu_hold` value after reset (1 = the core waits for its first load).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load session; sampled only in IDLE.
- `len` in AW+1: number of words to load, valid range 1..NMEM; sampled with `start`.
- `base` in AW: first word index; sampled with `start`.
- `abort` in 1: cancel the active session.
- `wr_valid` in 1: host word valid.
- `wr_data` in 32: host instruction word.
- `wr_ready` out 1: controller accepts a word this cycle.
- `im_add` out 32: memory word index, zero-extended from AW bits.
- `im_data` out 32: write data to the memory.
- `im_en` out 1: memory port enabled.
- `im_rd_wr` out 1: write strobe, one cycle per word.
- `cpu_hold` out 1: holds the core's fetch/pipeline.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: sticky error flag; cleared by the next accepted `start`.

## Operation
- **States.** IDLE, LOAD, SETTLE, DONE.
- **IDLE.**
  - On `start`, register `len` and `base`, clear `count` and `err`.
  - If `len`==0 or `len`>NMEM: stay in IDLE, set `err`, perform no writes, leave `cpu_hold` unchanged.
  - Otherwise go to LOAD and set `cpu_hold`=1.
- **LOAD.**
  - `wr_ready` = (state==LOAD) & !`abort`. This is the only combinational output.
  - On a handshake (`wr_valid` & `wr_ready`): register `im_data`=`wr_data` and `im_add`=(`base`+`count`) mod NMEM, so the AW-bit sum wraps. Assert `im_rd_wr` for the next cycle only, then increment `count`.
  - When the handshake makes `count`==`len`, go to SETTLE.
- **SETTLE.** One cycle. The final write strobe is on the port and `wr_ready`=0. Go to DONE.
- **DONE.** One cycle. `done`=1, `cpu_hold`=0. Go to IDLE.
- **`im_en`.** Equals `busy`, registered.
- **`im_rd_wr`.** Never asserted outside a cycle that follows a handshake.
- **`abort`.**
  - In LOAD or SETTLE, `abort` forces IDLE next cycle and sets `err`.
  - `cpu_hold` stays 1, so the core never runs a partial image.
  - A write already registered in the previous cycle still completes. No new handshake is accepted in the `abort` cycle.
- **`start` while busy.** Ignored.
- **`abort` in IDLE.** Ignored.
- **Simultaneous `abort` and last handshake.** `abort` wins: the word is not accepted and `done` is not pulsed.
- **Reset mid-session.** Returns to IDLE on the next edge. Any pending strobe is dropped.
- **Reset values.**
  - state=IDLE, `count`=0.
  - `im_add`=0, `im_data`=0, `im_en`=0, `im_rd_wr`=0.
  - `busy`=0, `done`=0, `err`=0.
  - `cpu_hold`=`HOLD_ON_RESET`.

## Timing
- `start` sampled at cycle 0 → LOAD, `busy`=1 and `cpu_hold`=1 at cycle 1; `wr_ready` can first be high at cycle 1.
- Handshake at cycle k → `im_rd_wr`=1 with a valid `im_add`/`im_data` at cycle k+1 (latency 1).
- Throughput: one word per cycle with `wr_valid` held high, so N words take N cycles of LOAD.
- Last handshake at cycle k → SETTLE at k+1, DONE at k+2 (`done`=1, `cpu_hold`=0), IDLE at k+3.
- Minimum session: `len`=1 spans 4 cycles from `start`.
- Back-to-back sessions: a new `start` is accepted at the first IDLE cycle after DONE.

## Structure
- **Package `im_loader_pkg`.**
  - State enum: IDLE, LOAD, SETTLE, DONE.
  - `NMEM`/`AW` defaults.
  - Address-wrap helper function: (`base`+`count`) truncated to AW bits.
- **Sub-module `im_wr_stage`.**
  - A natural split: the registered write port holding `im_add`/`im_data`/`im_rd_wr`, with a load enable and a flush input.
  - The FSM and counters stay in the top module.
- **Top-level integration.** The instruction memory's own clear input is driven by system reset in the top level, not by this block.

## Test plan
- Reset with `HOLD_ON_RESET`=1 → all outputs 0 except `cpu_hold`=1; `start`, `len`=4, `base`=0, words 0xA0..0xA3 back-to-back → strobes at indices 0..3 on 4 consecutive cycles, `done` 2 cycles after the last handshake, `cpu_hold` falls with `done`.
- `base`=126, `len`=4 → writes at indices 126, 127, 0, 1 (wrap); `im_add` upper 25 bits are 0.
- `wr_valid` toggled 1,0,1,0 for `len`=2 → exactly 2 strobes, each one cycle after its handshake; no strobe in the gap cycles.
- `len`=0, then `len`=129 → `err`=1, no `im_rd_wr`, `busy` stays 0; the following valid `start` clears `err`.
- `abort` together with the 3rd handshake of `len`=5 → 2 strobes only, `err`=1, `cpu_hold`=1, no `done`; a `start` during LOAD is ignored.
- `rst` asserted in LOAD → IDLE next cycle, `im_rd_wr`=0, `cpu_hold`=`HOLD_ON_RESET`.
